// File: rtl/noc_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 flit demux.
package noc_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int NUM_PORTS  = 4;

    localparam logic [3:0] SEL_P0 = 4'b0001;
    localparam logic [3:0] SEL_P1 = 4'b0010;
    localparam logic [3:0] SEL_P2 = 4'b0100;
    localparam logic [3:0] SEL_P3 = 4'b1000;

    // A select routes a flit only when exactly one port bit is set.
    function automatic logic sel_legal(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/fifo_2.sv
// Two-entry in-order FIFO; the head reads as zero while empty.
module fifo_2
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_4_buf.sv
// One-hot routed 1-to-4 demux with a 2-entry buffer per output port
// and a saturating counter of flits dropped for an illegal select.
module demux_4_buf
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            sel,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o_0,
    output logic [DATA_WIDTH-1:0] data_o_1,
    output logic [DATA_WIDTH-1:0] data_o_2,
    output logic [DATA_WIDTH-1:0] data_o_3,
    output logic [3:0]            valid_o,
    input  logic [3:0]            ready_i,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    logic                  legal;
    logic                  drop;
    logic [3:0]            full;
    logic [3:0]            empty;
    logic [3:0]            push;
    logic [3:0]            pop;
    logic [DATA_WIDTH-1:0] head [NUM_PORTS];

    assign legal = sel_legal(sel);

    // Illegal selects are always accepted so they can be discarded.
    assign ready_o = !legal || ((sel & full) == 4'b0000);
    assign push    = (valid_i && legal && ready_o) ? sel : 4'b0000;
    assign drop    = valid_i && !legal;

    assign valid_o = ~empty;
    assign pop     = valid_o & ready_i;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        fifo_2 #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[k]),
            .pop     (pop[k]),
            .data_in (data_i),
            .data_out(head[k]),
            .full    (full[k]),
            .empty   (empty[k])
        );
    end

    assign data_o_0 = head[0];
    assign data_o_1 = head[1];
    assign data_o_2 = head[2];
    assign data_o_3 = head[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_o <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_4_buf.sv
// Scoreboard bench: stimulus pushes expected flits per port, a monitor
// pops and compares them as the DUT presents each flit.
module tb_demux_4_buf;
    import noc_pkg::*;

    localparam int DW  = 4;
    localparam int CNW = 8;
    localparam int CNT_MAX = (1 << CNW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     sel;
    logic           valid_i;
    logic [DW-1:0]  data_i;
    logic           ready_o;
    logic [DW-1:0]  data_o_0;
    logic [DW-1:0]  data_o_1;
    logic [DW-1:0]  data_o_2;
    logic [DW-1:0]  data_o_3;
    logic [3:0]     valid_o;
    logic [3:0]     ready_i;
    logic           err_o;
    logic [CNW-1:0] drop_cnt;

    demux_4_buf #(.DATA_WIDTH(DW), .CNT_WIDTH(CNW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .data_o_0(data_o_0),
        .data_o_1(data_o_1),
        .data_o_2(data_o_2),
        .data_o_3(data_o_3),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q [4][$];
    int  pend [4];
    int  drops = 0;
    int  cnt_vis = 0;
    bit  last_ill = 0;
    bit  err_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int d);
        return (d > CNT_MAX) ? CNT_MAX : d;
    endfunction

    function automatic logic [DW-1:0] head_of(input int k);
        case (k)
            0:       return data_o_0;
            1:       return data_o_1;
            2:       return data_o_2;
            default: return data_o_3;
        endcase
    endfunction

    // One input cycle: drive after the falling edge, predict acceptance.
    task automatic cyc(input logic v, input logic [3:0] s,
                       input logic [DW-1:0] d, input logic [3:0] r);
        int  k;
        int  ones;
        bit  exp_rdy;
        @(negedge clk);
        for (int p = 0; p < 4; p++) pend[p] = 0;
        err_exp  = last_ill;
        last_ill = 0;
        cnt_vis  = drops;
        valid_i  = v;
        sel      = s;
        data_i   = d;
        ready_i  = r;
        #1;
        ones = 0;
        k    = 0;
        for (int p = 0; p < 4; p++) begin
            if (s[p]) begin
                ones++;
                k = p;
            end
        end
        exp_rdy = (ones == 1) ? (q[k].size() < FIFO_DEPTH) : 1'b1;
        chk("ready_o", int'(ready_o), int'(exp_rdy));
        if (v && exp_rdy) begin
            if (ones == 1) begin
                q[k].push_back(d);
                pend[k] = 1;
            end else begin
                last_ill = 1;
                drops++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data2", int'(data_o_2), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        for (int p = 0; p < 4; p++) begin
            q[p].delete();
            pend[p] = 0;
        end
        drops    = 0;
        cnt_vis  = 0;
        last_ill = 0;
        err_exp  = 0;
        valid_i  = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: compares presented flits with the scoreboard heads.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 4; k++) begin
                bit ev;
                ev = (q[k].size() > pend[k]);
                chk($sformatf("valid_o[%0d]", k), int'(valid_o[k]), int'(ev));
                if (ev) begin
                    chk($sformatf("data_o_%0d", k), int'(head_of(k)), int'(q[k][0]));
                    if (ready_i[k]) void'(q[k].pop_front());
                end else begin
                    chk($sformatf("data_o_%0d_idle", k), int'(head_of(k)), 0);
                end
            end
            chk("err_o", int'(err_o), int'(err_exp));
            chk("drop_cnt", int'(drop_cnt), sat(cnt_vis));
        end
    end

    initial begin
        logic [3:0] s;
        for (int p = 0; p < 4; p++) pend[p] = 0;
        rst     = 1'b1;
        sel     = 4'b0000;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 4'b0000;
        #3;
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_err", int'(err_o), 0);
        chk("reset_drop", int'(drop_cnt), 0);
        chk("reset_ready", int'(ready_o), 1);
        chk("reset_data0", int'(data_o_0), 0);
        @(negedge clk);
        #3;
        rst = 1'b0;

        // Streaming to port 2.
        cyc(1, SEL_P2, 4'hA, 4'hF);
        cyc(1, SEL_P2, 4'hB, 4'hF);
        cyc(1, SEL_P2, 4'hC, 4'hF);
        repeat (3) cyc(0, 4'b0000, 4'h0, 4'hF);

        // Port 1 backpressured, port 3 still accepts.
        cyc(1, SEL_P1, 4'h1, 4'b1101);
        cyc(1, SEL_P1, 4'h2, 4'b1101);
        cyc(1, SEL_P1, 4'h3, 4'b1101);
        cyc(1, SEL_P3, 4'h7, 4'b1101);
        cyc(0, 4'b0000, 4'h0, 4'b1101);
        repeat (3) cyc(0, 4'b0000, 4'h0, 4'hF);

        // Illegal select, then saturation of the drop counter.
        cyc(1, 4'b0011, 4'h5, 4'hF);
        cyc(0, 4'b0000, 4'h0, 4'hF);
        chk("drop_one", int'(drop_cnt), 1);
        for (int i = 0; i < 299; i++) cyc(1, 4'b0000, 4'(i), 4'hF);
        cyc(0, 4'b0000, 4'h0, 4'hF);
        chk("drop_sat", int'(drop_cnt), CNT_MAX);

        // Push and pop of a one-entry FIFO in the same cycle.
        cyc(1, SEL_P0, 4'h5, 4'b1110);
        cyc(1, SEL_P0, 4'h6, 4'hF);
        repeat (2) cyc(0, 4'b0000, 4'h0, 4'hF);

        // Asynchronous reset with two flits buffered on port 2.
        cyc(1, SEL_P2, 4'h8, 4'b1011);
        cyc(1, SEL_P2, 4'h9, 4'b1011);
        cyc(0, 4'b0000, 4'h0, 4'b1011);
        do_reset();
        repeat (3) cyc(0, 4'b0000, 4'h0, 4'hF);

        // Random legal and illegal traffic.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do s = 4'($urandom_range(0, 15)); while (sel_legal(s));
            end else begin
                s = 4'b0001 << $urandom_range(0, 3);
            end
            cyc(1'($urandom_range(0, 3) != 0), s,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        repeat (4) cyc(0, 4'b0000, 4'h0, 4'hF);
        chk("final_drops", int'(drop_cnt), sat(drops));
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("drained_%0d", p), q[p].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_4_buf.md
DEMUX_4_BUF -- requirements
Module: demux_4_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, flit payload width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the drop counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sel  input  4  one-hot output select, qualified by valid_i; bit k selects port k.
REQ-006 SHALL have port valid_i  input  1  input flit valid.
REQ-007 SHALL have port data_i  input  DATA_WIDTH  input flit payload.
REQ-008 SHALL have port ready_o  output  1  input accept; handshake occurs when valid_i and ready_o are both high.
REQ-009 SHALL have ports data_o_0..data_o_3  output  DATA_WIDTH each  per-port payload.
REQ-010 SHALL have port valid_o  output  4  per-port flit valid, bit k for port k.
REQ-011 SHALL have port ready_i  input  4  per-port downstream ready, bit k for port k.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse flagging a dropped flit.
REQ-013 SHALL have port drop_cnt  output  CNT_WIDTH  count of dropped flits.

Function
REQ-014 SHALL treat sel as legal only when exactly one bit is set; 4'b0000 and any multi-bit value are illegal.
REQ-015 SHALL give each output port k a 2-entry in-order FIFO.
REQ-016 SHALL drive ready_o combinationally: 1 if sel is illegal, else the inverse of full[k] for the selected k.
REQ-017 SHALL push data_i into FIFO k on a handshake with legal sel, and SHALL leave all other FIFOs unchanged.
REQ-018 SHALL have a latency of 1 cycle: a flit accepted at edge N is visible on valid_o[k] and data_o_k after edge N.
REQ-019 SHALL drive valid_o[k] as FIFO k non-empty and data_o_k as FIFO k head; data_o_k SHALL be 0 when FIFO k is empty.
REQ-020 SHALL pop FIFO k when valid_o[k] and ready_i[k] are both high.
REQ-021 SHALL hold data_o_k and valid_o[k] stable while valid_o[k]=1 and ready_i[k]=0.
REQ-022 SHALL, on a simultaneous push and pop of the same FIFO holding 1 entry, keep the count at 1 and present the new flit next cycle.
REQ-023 SHALL, on a simultaneous push and pop of a full FIFO, stall the push, because ready_o was already 0.
REQ-024 SHALL sustain 1 flit/cycle per port with ready_i held high; a full FIFO SHALL NOT stall flits selecting a different port.
REQ-025 SHALL discard a flit when a handshake occurs with illegal sel, pulse err_o high for exactly the following cycle, and increment drop_cnt.
REQ-026 SHALL saturate drop_cnt at 2^CNT_WIDTH-1.
REQ-027 SHALL ignore sel and data_i while valid_i=0.

Reset
REQ-028 SHALL, while rst is high, empty all FIFOs and force valid_o=0, all data_o_k=0, err_o=0, drop_cnt=0, independent of clk.
REQ-029 SHALL discard all buffered flits when reset is asserted mid-operation; no flit SHALL appear after deassertion without a new handshake.
REQ-030 SHALL drive ready_o per REQ-016 during reset, with all FIFOs empty.

Structure
REQ-031 SHALL place the one-hot select constants (SEL_P0..SEL_P3) and FIFO_DEPTH=2 in the shared package noc_pkg.
REQ-032 SHALL implement each port buffer by instantiating one sub-module fifo_2 (2-entry FIFO with push/pop/full/empty); the instance count is 4.

Verification
REQ-033 SHALL be verified as follows: stream 0xA,0xB,0xC with sel=4'b0100 and ready_i=4'b1111 -> valid_o[2] high on 3 consecutive cycles, each 1 cycle after its handshake, data_o_2 = A,B,C, other ports idle.
REQ-034 SHALL be verified as follows: ready_i[1]=0, push 3 flits to port 1 -> ready_o drops after 2 accepts; then push a flit to port 3 -> accepted, appears on data_o_3.
REQ-035 SHALL be verified as follows: sel=4'b0011 with valid_i=1 for one cycle -> ready_o=1, no valid_o rises, err_o=1 for one cycle, drop_cnt=1; 300 illegal flits -> drop_cnt=255.
REQ-036 SHALL be verified as follows: port 0 holding 1 entry, push and pop port 0 in the same cycle -> valid_o[0] stays 1 and data_o_0 shows the new flit next cycle.
REQ-037 SHALL be verified as follows: 2 flits buffered on port 2, assert rst between clock edges -> valid_o=0, data_o_2=0 immediately; after deassertion valid_o stays 0 with no input.
REQ-038 SHALL be verified as follows: random legal/illegal sel, random ready_i, 10k cycles -> per-port scoreboard preserves order with no loss or duplication, and drop_cnt equals the illegal-handshake count.
